// File: rtl/matvec_mult_param.sv
// Parametrised matrix-vector multiplier: c = A*b with ROWS parallel MAC lanes,
// one column per clock, optional accumulate onto previous results and sticky overflow.
module matvec_mult_param #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DW     = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      accum,
  input  logic [ROWS*COLS*DW-1:0]   a_data,
  input  logic [COLS*DW-1:0]        b_data,
  output logic [ROWS*ACC_W-1:0]     c_out,
  output logic [ROWS-1:0]           ovf,
  output logic                      busy,
  output logic                      done
);

  // state   | meaning
  // S_IDLE  | waiting for start, results held
  // S_RUN   | one MAC column per clock, k = column index
  // S_DONE  | results valid, waiting for next start or clr
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(COLS - 1);

  logic [1:0]                 state;
  logic [KW-1:0]              k;
  logic [ROWS*COLS*DW-1:0]    a_q;
  logic [COLS*DW-1:0]         b_q;
  logic [ROWS*ACC_W-1:0]      c_q;
  logic [ROWS-1:0]            ovf_q;
  logic [ROWS*ACC_W-1:0]      c_nxt;
  logic [ROWS-1:0]            ovf_add;
  logic [DW-1:0]              b_k;

  assign b_k = b_q[k*DW +: DW];

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DW-1:0]    a_rk;
    logic [2*DW-1:0]  prod;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign a_rk = a_q[(r*COLS + k)*DW +: DW];
    assign acc  = c_q[r*ACC_W +: ACC_W];
    assign sum  = acc + ext;
    assign c_nxt[r*ACC_W +: ACC_W] = sum;

    if (SIGNED != 0) begin : g_signed
      assign prod = $signed({{DW{a_rk[DW-1]}}, a_rk}) * $signed({{DW{b_k[DW-1]}}, b_k});
      assign ext  = ACC_W'($signed(prod));
      assign ovf_add[r] = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end else begin : g_unsigned
      assign prod = {{DW{1'b0}}, a_rk} * {{DW{1'b0}}, b_k};
      assign ext  = ACC_W'(prod);
      // a wrapped unsigned sum is smaller than either addend exactly when it carried out
      assign ovf_add[r] = (sum < acc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ovf_q <= '0;
    end else if (clr) begin
      state <= S_IDLE;
      k     <= '0;
      c_q   <= '0;
      ovf_q <= '0;
    end else begin
      case (state)
        S_RUN: begin
          c_q   <= c_nxt;
          ovf_q <= ovf_q | ovf_add;
          k     <= k + 1'b1;
          if (k == K_LAST) state <= S_DONE;
        end
        default: begin
          if (start) begin
            state <= S_RUN;
            k     <= '0;
            a_q   <= a_data;
            b_q   <= b_data;
            if (!accum) begin
              c_q   <= '0;
              ovf_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign c_out = c_q;
  assign ovf   = ovf_q;
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_matvec_mult_param.sv
// Directed bench for matvec_mult_param: default, signed and narrow-accumulator
// instances share stimulus; each step checks hand-computed results.
module tb_matvec_mult_param;

  logic         clk = 1'b0;
  logic         rst, clr, start, accum;
  logic [511:0] a_data;
  logic [63:0]  b_data;

  logic [191:0] c_out;   logic [7:0] ovf;   logic busy,   done;
  logic [191:0] c_s;     logic [7:0] ovf_s; logic busy_s, done_s;
  logic [127:0] c_n;     logic [7:0] ovf_n; logic busy_n, done_n;

  int checks = 0;
  int failures = 0;

  matvec_mult_param dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .accum(accum),
    .a_data(a_data), .b_data(b_data), .c_out(c_out), .ovf(ovf), .busy(busy), .done(done));

  matvec_mult_param #(.SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .accum(accum),
    .a_data(a_data), .b_data(b_data), .c_out(c_s), .ovf(ovf_s), .busy(busy_s), .done(done_s));

  matvec_mult_param #(.ACC_W(16)) dut_n (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .accum(accum),
    .a_data(a_data), .b_data(b_data), .c_out(c_n), .ovf(ovf_n), .busy(busy_n), .done(done_n));

  always #5 clk = ~clk;

  localparam logic [23:0] EXP1 [8] = '{24'h24, 24'hA4, 24'h10, 24'h18, 24'h20, 24'h28, 24'h30, 24'h38};
  localparam logic [23:0] EXP2 [8] = '{24'h48, 24'h148, 24'h20, 24'h30, 24'h40, 24'h50, 24'h60, 24'h70};

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic load_pattern1();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        a_data[(r*8+k)*8 +: 8] = (r == 0) ? 8'(k + 1) : (r == 1) ? 8'(8'h11 + k) : 8'(r);
    for (int k = 0; k < 8; k++) b_data[k*8 +: 8] = 8'h01;
  endtask

  task automatic pulse_start(input logic acc);
    start = 1'b1; accum = acc;
    tick();
    start = 1'b0; accum = 1'b0;
  endtask

  task automatic check_rows(input string tag, input logic [23:0] exp [8]);
    for (int r = 0; r < 8; r++)
      check($sformatf("%s_row%0d", tag, r), 192'(c_out[r*24 +: 24]), 192'(exp[r]));
  endtask

  initial begin
    int n;
    bit seen_done;
    rst = 1'b1; clr = 1'b0; start = 1'b0; accum = 1'b0;
    a_data = '0; b_data = '0;
    tick(); tick();
    check("reset_c", c_out, '0);
    check("reset_ovf", 192'(ovf), '0);
    check("reset_busy", 192'(busy), '0);
    check("reset_done", 192'(done), '0);
    rst = 1'b0;
    tick();

    // basic multiply
    load_pattern1();
    pulse_start(1'b0);
    check("s1_busy_after_start", 192'(busy), 192'(1));
    wait_busy(n);
    check("s1_busy_cycles", 192'(n), 192'(8));
    check("s1_done", 192'(done), 192'(1));
    check_rows("s1", EXP1);
    check("s1_ovf", 192'(ovf), '0);

    // accumulate onto previous results
    pulse_start(1'b1);
    wait_busy(n);
    check("s2_busy_cycles", 192'(n), 192'(8));
    check_rows("s2", EXP2);
    check("s2_done", 192'(done), 192'(1));

    // signed instance: -1 * 2 summed eight times
    a_data = {64{8'hFF}};
    b_data = {8{8'h02}};
    pulse_start(1'b0);
    wait_busy(n);
    for (int r = 0; r < 8; r++)
      check($sformatf("s3_signed_row%0d", r), 192'(c_s[r*24 +: 24]), 192'(24'hFFFFF0));
    check("s3_signed_ovf", 192'(ovf_s), '0);

    // 16-bit accumulator overflows: 8*0xFE01 = 0x7F008
    a_data = {64{8'hFF}};
    b_data = {8{8'hFF}};
    pulse_start(1'b0);
    wait_busy(n);
    for (int r = 0; r < 8; r++)
      check($sformatf("s4_narrow_row%0d", r), 192'(c_n[r*16 +: 16]), 192'(16'hF008));
    check("s4_narrow_ovf", 192'(ovf_n), 192'(8'hFF));
    a_data = '0;
    b_data = '0;
    pulse_start(1'b0);
    wait_busy(n);
    check("s4_cleared_ovf", 192'(ovf_n), '0);
    check("s4_cleared_c", 192'(c_n), '0);

    // clr aborts mid-run
    load_pattern1();
    pulse_start(1'b0);
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("s5_busy_after_clr", 192'(busy), '0);
    check("s5_c_after_clr", c_out, '0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("s5_done_never", 192'(seen_done), '0);

    // start during RUN is ignored, including its accum and new operands
    pulse_start(1'b0);
    tick(); tick(); tick();
    a_data = '0;
    pulse_start(1'b1);
    load_pattern1();
    wait_busy(n);
    check("s6_busy_cycles", 192'(n + 4), 192'(8));
    check_rows("s6", EXP1);

    // async reset mid-run
    pulse_start(1'b0);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    check("s7_rst_c", c_out, '0);
    check("s7_rst_busy", 192'(busy), '0);
    check("s7_rst_done", 192'(done), '0);
    check("s7_rst_ovf", 192'(ovf), '0);
    tick();
    rst = 1'b0;
    tick();
    check("s7_idle_busy", 192'(busy), '0);
    check("s7_idle_done", 192'(done), '0);
    pulse_start(1'b0);
    wait_busy(n);
    check("s7_busy_cycles", 192'(n), 192'(8));
    check_rows("s7", EXP1);
    check("s7_not_both", 192'(busy & done), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
